// File: rtl/argon_mem_pkg.sv
// Shared types and constants for the Argon memory responder.
// Included by argon_mem_responder and argon_mem_array.
package argon_mem_pkg;

   localparam int WORD_BYTES     = 4;
   localparam int BE_WIDTH       = WORD_BYTES;
   localparam int WAIT_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } state_t;

endpackage

// File: rtl/argon_mem_array.sv
// Single-port word RAM with byte-lane writes and registered read data.
module argon_mem_array
   import argon_mem_pkg::*;
#(
   parameter int    ADDR_WIDTH = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic                  i_clk,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [BE_WIDTH-1:0]   i_be,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // Read data only updates on read accesses, so it holds through the response.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
               if (i_be[i]) begin
                  mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
               end
            end
         end else begin
            o_rdata <= mem[i_addr];
         end
      end
   end

endmodule

// File: rtl/argon_mem_responder.sv
// Memory responder: one outstanding request, WAIT_CYCLES wait states, error on bad address.
// Define ARGON_MEM_STATS_EN to add read/write/error response counters.
//
// state  | meaning
// IDLE   | ready for a request
// WAIT   | counting down programmed wait states
// ACCESS | one-cycle array access (or error decision)
// RESP   | response held until accepted
module argon_mem_responder
   import argon_mem_pkg::*;
#(
   parameter int    ADDR_WIDTH  = 12,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_write,
   input  logic [31:0]         i_req_addr,
   input  logic [31:0]         i_req_wdata,
   input  logic [BE_WIDTH-1:0] i_req_be,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [31:0]         o_rsp_rdata,
   output logic                o_rsp_err,
`ifdef ARGON_MEM_STATS_EN
   output logic [31:0]         o_stat_reads,
   output logic [31:0]         o_stat_writes,
   output logic [31:0]         o_stat_errors,
`endif
   output logic                o_busy
);

   localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_INIT = WAIT_CNT_WIDTH'(WAIT_CYCLES);

   state_t                    state, state_nxt;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;
   logic                      req_write;
   logic [31:0]               req_addr;
   logic [31:0]               req_wdata;
   logic [BE_WIDTH-1:0]       req_be;
   logic                      accept;
   logic                      rsp_hs;
   logic                      addr_err;
   logic                      arr_en;
   logic                      arr_we;
   logic [31:0]               arr_rdata;

   assign o_req_ready = (state == IDLE) & ~i_reset;
   assign accept      = i_req_valid & o_req_ready;
   assign rsp_hs      = (state == RESP) & i_rsp_ready;

   // Any bit above the RAM's byte range, or a sub-word offset, is an error.
   assign addr_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               wait_cnt_nxt = WAIT_INIT;
               state_nxt    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            wait_cnt_nxt = wait_cnt - 1'b1;
            if (wait_cnt <= 1) state_nxt = ACCESS;
         end
         ACCESS:  state_nxt = RESP;
         RESP:    if (i_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         req_write <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_be    <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            req_write <= i_req_write;
            req_addr  <= i_req_addr;
            req_wdata <= i_req_wdata;
            req_be    <= i_req_be;
         end
      end
   end

   // Write gated with reset so a reset coinciding with ACCESS never commits a partial store.
   assign arr_en = (state == ACCESS) & ~addr_err;
   assign arr_we = req_write & ~i_reset;

   argon_mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .i_clk   (i_clk),
      .i_en    (arr_en),
      .i_we    (arr_we),
      .i_be    (req_be),
      .i_addr  (req_addr[ADDR_WIDTH+1:2]),
      .i_wdata (req_wdata),
      .o_rdata (arr_rdata)
   );

   assign o_rsp_valid = (state == RESP);
   assign o_rsp_err   = (state == RESP) & addr_err;
   assign o_rsp_rdata = ((state == RESP) && !req_write && !addr_err) ? arr_rdata : 32'd0;
   assign o_busy      = (state != IDLE);

`ifdef ARGON_MEM_STATS_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_stat_reads  <= '0;
         o_stat_writes <= '0;
         o_stat_errors <= '0;
      end else if (rsp_hs) begin
         if (addr_err)       o_stat_errors <= o_stat_errors + 1'b1;
         else if (req_write) o_stat_writes <= o_stat_writes + 1'b1;
         else                o_stat_reads  <= o_stat_reads + 1'b1;
      end
   end
`endif

endmodule
